// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with 16x oversampling, presenting bytes on a one-deep AXI4-Stream register.
// Framing errors and dropped bytes (output still full) are flagged with single-cycle pulses.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a low level on rxd_s
// S_START | timing the start bit, verify it mid-bit
// S_DATA  | sampling 8 data bits mid-bit, LSB first
// S_STOP  | sampling the stop bit, deliver / drop / flag the byte
// S_BRK   | line held low after a framing error, wait for it to go high
module uart_rx_axis #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TICK_DIV  = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE)
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       rx_byte_tvalid,
  input  logic       rx_byte_tready,
  output logic [7:0] rx_byte_tdata,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            rxd_m, rxd_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      samp_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            clr_cnt, clr_samp, shift_en, stop_ok, stop_bad;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  // Oversample timer counts down; reloading it on the start edge aligns ticks to the character.
  assign tick = (tick_cnt == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    clr_samp  = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxd_s) begin
          state_nxt = S_START;
          clr_cnt   = 1'b1;
        end
      end
      S_START: begin
        if (tick && samp_cnt == 4'd7) begin
          if (rxd_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            clr_samp  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick && samp_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && samp_cnt == 4'd15) begin
          if (rxd_s) begin
            stop_ok   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rxd_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tick_cnt  <= '0;
      samp_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (clr_cnt || tick) tick_cnt <= TICK_LAST;
      else                 tick_cnt <= tick_cnt - 1'b1;

      if (clr_cnt || clr_samp) samp_cnt <= 4'd0;
      else if (tick)           samp_cnt <= samp_cnt + 4'd1;

      if (clr_samp)      bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_reg[bit_idx] <= rxd_s;
    end
  end

  // An accept in the same cycle as a new byte frees the slot, so that byte is not an overrun.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_byte_tvalid <= 1'b0;
      rx_byte_tdata  <= 8'h00;
      frame_err      <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_byte_tvalid && !rx_byte_tready;
      if (stop_ok && (!rx_byte_tvalid || rx_byte_tready)) begin
        rx_byte_tdata  <= shift_reg;
        rx_byte_tvalid <= 1'b1;
      end else if (rx_byte_tvalid && rx_byte_tready) begin
        rx_byte_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: serial stimulus at nominal and skewed baud rates,
// compared against a character-level model of what the downstream side should see.
`timescale 1ns/1ps
module tb_uart_rx_axis;

  localparam int  CLK_FREQ  = 1_600_000;
  localparam int  BAUD_RATE = 10_000;
  localparam int  TICK_DIV  = 10;
  localparam real BIT_NS    = 1600.0;
  localparam int  LATENCY   = 2 + (8 + 16 * 9) * TICK_DIV + 1;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_byte_tvalid;
  logic       rx_byte_tready = 1'b1;
  logic [7:0] rx_byte_tdata;
  logic       frame_err;
  logic       overrun_err;

  uart_rx_axis #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .uart_rxd      (uart_rxd),
    .rx_byte_tvalid(rx_byte_tvalid),
    .rx_byte_tready(rx_byte_tready),
    .rx_byte_tdata (rx_byte_tdata),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Observed side
  logic [7:0] got_q[$];
  int f_hi = 0, f_cnt = 0, o_hi = 0, o_cnt = 0, rise_cyc = -1;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_o = 1'b0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (rx_byte_tvalid && rx_byte_tready) got_q.push_back(rx_byte_tdata);
      if (rx_byte_tvalid && !prev_v) rise_cyc = cyc;
      if (frame_err) f_hi++;
      if (frame_err && !prev_f) f_cnt++;
      if (overrun_err) o_hi++;
      if (overrun_err && !prev_o) o_cnt++;
    end
    prev_v = rx_byte_tvalid;
    prev_f = frame_err;
    prev_o = overrun_err;
  end

  // Character-level model: a good character is delivered unless the single output slot is
  // still occupied by an unaccepted byte; a bad stop bit yields one framing error.
  logic [7:0] exp_q[$];
  int exp_frame = 0, exp_ovr = 0;
  bit slot_full = 1'b0;

  task automatic model_char(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) exp_frame++;
    else if (!rx_byte_tready && slot_full) exp_ovr++;
    else begin
      if (!rx_byte_tready) slot_full = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input real bt, input logic stop_bit);
    uart_rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #(bt);
    end
    uart_rxd = stop_bit;
    #(bt);
  endtask

  task automatic send_model(input logic [7:0] b, input real bt);
    model_char(b, 1'b1);
    send_byte(b, bt, 1'b1);
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    f_hi = 0; f_cnt = 0; o_hi = 0; o_cnt = 0;
    exp_frame = 0; exp_ovr = 0;
    slot_full = 1'b0;
    rise_cyc = -1;
  endtask

  task automatic check_scn(input string name);
    chk({name, ".beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
    chk({name, ".frame_pulses"}, f_cnt, exp_frame);
    chk({name, ".frame_cycles"}, f_hi, exp_frame);
    chk({name, ".overrun_pulses"}, o_cnt, exp_ovr);
    chk({name, ".overrun_cycles"}, o_hi, exp_ovr);
    clear_all();
  endtask

  initial begin
    int t0, d, lat_obs;
    real pct, bt;
    logic [7:0] b2b [4];
    b2b[0] = 8'h7D; b2b[1] = 8'hA3; b2b[2] = 8'h00; b2b[3] = 8'hFF;

    #100;
    chk("reset.tvalid", int'(rx_byte_tvalid), 0);
    chk("reset.tdata", int'(rx_byte_tdata), 0);
    chk("reset.frame_err", int'(frame_err), 0);
    chk("reset.overrun_err", int'(overrun_err), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #(2 * BIT_NS);
    clear_all();

    // Single byte with latency
    @(posedge aclk);
    #1;
    t0 = cyc;
    send_model(8'h55, BIT_NS);
    #(2 * BIT_NS);
    d = rise_cyc - t0;
    lat_obs = (d >= LATENCY - 2 && d <= LATENCY + 2) ? LATENCY : d;
    chk("single.latency", lat_obs, LATENCY);
    check_scn("single");

    // Back-to-back at nominal, +3% and -3% sender baud
    for (int r = 0; r < 3; r++) begin
      pct = (r == 0) ? 0.0 : ((r == 1) ? 3.0 : -3.0);
      bt  = BIT_NS / (1.0 + pct / 100.0);
      for (int i = 0; i < 4; i++) send_model(b2b[i], bt);
      #(2 * BIT_NS);
      check_scn($sformatf("b2b%0d", r));
    end

    // Glitch shorter than half a bit
    uart_rxd = 1'b0;
    #400;
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    check_scn("glitch");
    send_model(8'h3C, BIT_NS);
    #(2 * BIT_NS);
    check_scn("post_glitch");

    // Framing error followed by a held-low line
    model_char(8'h00, 1'b0);
    send_byte(8'h00, BIT_NS, 1'b0);
    #5000;
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    send_model(8'h81, BIT_NS);
    #(2 * BIT_NS);
    check_scn("frame");

    // Overrun with the output stalled
    @(posedge aclk);
    #1;
    rx_byte_tready = 1'b0;
    send_model(8'h11, BIT_NS);
    send_model(8'h22, BIT_NS);
    #(2 * BIT_NS);
    chk("overrun.held_tdata", int'(rx_byte_tdata), 8'h11);
    chk("overrun.held_tvalid", int'(rx_byte_tvalid), 1);
    @(posedge aclk);
    #1;
    rx_byte_tready = 1'b1;
    slot_full = 1'b0;
    #(2 * BIT_NS);
    check_scn("overrun");

    // Reset asserted mid data bit 3, held until the line is idle again
    fork
      send_byte(8'hC6, BIT_NS, 1'b1);
      begin
        #(4.5 * BIT_NS);
        aresetn = 1'b0;
        #1;
        chk("midreset.tvalid", int'(rx_byte_tvalid), 0);
        chk("midreset.tdata", int'(rx_byte_tdata), 0);
        chk("midreset.frame_err", int'(frame_err), 0);
        chk("midreset.overrun_err", int'(overrun_err), 0);
      end
    join
    #(BIT_NS);
    @(negedge aclk);
    aresetn = 1'b1;
    #(2 * BIT_NS);
    check_scn("midreset_quiet");
    send_model(8'h5A, BIT_NS);
    #(2 * BIT_NS);
    check_scn("midreset_next");

    // Randomized bytes, sender skew within +/-3%, random idle gaps
    for (int r = 0; r < 2; r++) begin
      pct = (real'($urandom_range(0, 600)) - 300.0) / 100.0;
      bt  = BIT_NS / (1.0 + pct / 100.0);
      for (int i = 0; i < 4; i++) begin
        send_model(8'($urandom_range(0, 255)), bt);
        #(real'($urandom_range(0, 2)) * bt);
      end
      #(2 * BIT_NS);
      check_scn($sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver that turns the asynchronous serial line into the 8-bit AXI4-Stream byte stream consumed by the framing stage's `rx_byte_*` input. It uses a 16x oversampled bit clock. Each character is 8N1: one start bit, 8 data bits LSB first, one stop bit. Framing and overrun errors are reported as single-cycle pulses. The output register holds one byte and obeys AXI4-Stream valid/ready rules.

## Interface
- `CLK_FREQ`, default 100_000_000: aclk frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `TICK_DIV`, default round(CLK_FREQ/(16*BAUD_RATE)) = 54: aclk cycles per oversample tick. Must be ≥ 2.
- `aclk`, in, 1: single clock.
- `aresetn`, in, 1: reset, asynchronous, active-low.
- `uart_rxd`, in, 1: serial line, asynchronous to aclk, idle high.
- `rx_byte_tvalid`, out, 1: received byte available.
- `rx_byte_tready`, in, 1: downstream accepts the byte.
- `rx_byte_tdata`, out, 8: received byte.
- `frame_err`, out, 1: one-cycle pulse when the stop bit samples 0.
- `overrun_err`, out, 1: one-cycle pulse when a byte is dropped because the output is still full.

## Operation
- Input synchronizer: 2-flop, reset value 1. All logic below uses the synchronized value `rxd_s`.
- Tick generator: counter 0..TICK_DIV-1 produces `tick` on the terminal count. It is cleared on entry to START, so ticks align to the start edge.
- Sample counter: 4 bits, 0..15, advances on `tick`. Bit counter: 3 bits.
- IDLE: if `rxd_s`==0, go to START and clear the tick counter and sample counter.
- START: on the 8th tick (mid start bit), sample `rxd_s`.
  - If 1: glitch. Return to IDLE; no output, no error.
  - If 0: clear the sample counter and go to DATA with bit index 0.
- DATA: every 16th tick, shift `rxd_s` into bit[index] (LSB first). After index 7, go to STOP.
- STOP: on the 16th tick, sample the stop bit.
  - If 1 and `rx_byte_tvalid`==0: load `rx_byte_tdata`, assert `rx_byte_tvalid`, go to IDLE.
  - If 1 and `rx_byte_tvalid`==1: pulse `overrun_err` and drop the new byte. Output data and valid stay unchanged. Go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, go to BRK.
- BRK: wait until `rxd_s`==1, then go to IDLE. This prevents a break condition from being taken as repeated start bits.
- Output handshake: `rx_byte_tvalid` clears on the cycle after `rx_byte_tvalid && rx_byte_tready`.
  - If a new byte completes in the same cycle as the accept, the new byte is loaded, valid stays 1, and no overrun is reported.
- `rx_byte_tdata` is stable while valid is high and not accepted.
- Reset values: `rx_byte_tvalid`=0, `rx_byte_tdata`=0x00, `frame_err`=0, `overrun_err`=0, state IDLE, all counters 0, synchronizer flops 1.
- Asserting reset mid-character aborts it. After release, the block waits in IDLE.
  - If the line is still low after release, the remainder of the aborted character can be misread as a new start bit. That behaviour is accepted, with no requirement on its output. The bench only checks that the next fully transmitted character after the line returns idle is received correctly.

## Timing
- Latency: `rx_byte_tvalid` rises 2 + (8 + 16*9)*TICK_DIV + 1 aclk cycles after the first edge that samples `uart_rxd` low, ±2 cycles.
- `frame_err` and `overrun_err` assert in the same cycle that `rx_byte_tvalid` would have risen. Each is high for exactly 1 cycle.
- Back-to-back characters with zero idle time are supported. The stop bit is sampled mid-bit, so IDLE is re-entered half a bit early, which gives resync margin.
- Tolerated baud mismatch: ±3% between sender and receiver.
- No combinational path from `rx_byte_tready` to any output.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=10_000, TICK_DIV=10 (160 clocks/bit), with `rx_byte_tready`=1 unless stated.
- Single byte: send 0x55, then idle. Required: one beat, tdata=0x55, valid rise at 1523±2 cycles after the start edge, no error pulses.
- Back-to-back: send 0x7D, 0xA3, 0x00, 0xFF with no idle gap. Required: four beats in order with exactly those values. Repeat with the sender at +3% and −3% baud; same result.
- Glitch: hold `uart_rxd` low for 40 clocks, then high. Required: no beat, no error, block back in IDLE. A following 0x3C is received correctly.
- Frame error: send 0x00 with stop bit 0, then 500 clocks of low line, then idle and 0x81. Required: exactly one `frame_err` pulse, no beat for the bad character, 0x81 received.
- Overrun: tready=0; send 0x11 then 0x22. Required: tdata stays 0x11, valid stays high, one `overrun_err` pulse at the end of 0x22. Raise tready: only 0x11 is delivered.
- Reset mid-byte: assert aresetn low during data bit 3 of 0xC6. Required: all outputs at reset values immediately, no beat for 0xC6 after release. After the line has returned idle, the next 0x5A is received correctly.
